uart_cmd_parser: RTL
====================

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter TIMEOUT_US, default 2000: inter-byte timeout in microseconds.
REQ-002 SHALL have parameter ADDR_W, default 24: PSRAM byte-address width.
REQ-003 SHALL have port clk, input, 1: single system clock.
REQ-004 SHALL have port arst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port tick_1us, input, 1: one-cycle strobe every 1 us.
REQ-006 SHALL have port rx_data, input, 8: byte from the UART receiver.
REQ-007 SHALL have port rx_valid, input, 1: one-cycle strobe; rx_data is valid.
REQ-008 SHALL have port cmd_valid, output, 1: PSRAM request pending.
REQ-009 SHALL have port cmd_ready, input, 1: PSRAM controller accepts the request.
REQ-010 SHALL have port cmd_we, output, 1: 1 = write, 0 = read.
REQ-011 SHALL have port cmd_addr, output, ADDR_W: request address.
REQ-012 SHALL have port cmd_wdata, output, 16: write data.
REQ-013 SHALL have port rd_data, input, 16: read result.
REQ-014 SHALL have port rd_valid, input, 1: one-cycle strobe; rd_data is valid.
REQ-015 SHALL have port tx_data, output, 8: byte to the UART transmitter.
REQ-016 SHALL have port tx_valid, output, 1: tx_data is valid.
REQ-017 SHALL have port tx_ready, input, 1: the transmitter accepts the byte.
REQ-018 SHALL have port err, output, 1: one-cycle pulse on a protocol error.

Function
REQ-019 SHALL decode the first byte as an opcode: 0x00 = READ, 0x01 = WRITE; any other value SHALL pulse err, be discarded, and leave the FSM in IDLE.
REQ-020 SHALL collect 3 address bytes after the opcode, MSB first, into cmd_addr[23:0].
REQ-021 SHALL, for WRITE, collect 2 further data bytes, MSB first, into cmd_wdata.
REQ-022 SHALL use FSM states IDLE, ADDR, DATA, ISSUE, WAIT_RD, TX_HI, TX_LO.
REQ-023 Transitions:
  - IDLE -> ADDR on a valid opcode.
  - ADDR -> DATA (WRITE) or ISSUE (READ) after the third address byte.
  - DATA -> ISSUE after the second data byte.
  - ISSUE -> IDLE (WRITE) or WAIT_RD (READ) on cmd_valid && cmd_ready.
  - WAIT_RD -> TX_HI on rd_valid.
  - TX_HI -> TX_LO on tx_valid && tx_ready.
  - TX_LO -> IDLE on tx_valid && tx_ready.
REQ-024 cmd_valid SHALL be high exactly while in ISSUE; cmd_we, cmd_addr and cmd_wdata SHALL stay stable while cmd_valid is high.
REQ-025 The request SHALL reach cmd_valid one clk after the final command byte's rx_valid.
REQ-026 rd_data SHALL be captured on rd_valid; tx_data SHALL be rd_data[15:8] in TX_HI and rd_data[7:0] in TX_LO; tx_valid SHALL be high only in TX_HI and TX_LO.
REQ-027 rx_valid in ISSUE, WAIT_RD, TX_HI or TX_LO SHALL pulse err, and the byte SHALL be dropped with no state change.
REQ-028 A 16-bit timeout counter SHALL clear on every rx_valid and increment on tick_1us while in ADDR or DATA.
REQ-029 On reaching TIMEOUT_US, the FSM SHALL go to IDLE, err SHALL pulse, and the partial command SHALL be discarded.
REQ-030 The timeout counter SHALL be held at 0 in all other states.
REQ-031 When rx_valid and a timeout occur in the same cycle, rx_valid SHALL win (the byte is accepted and the counter cleared).
REQ-032 Address bytes SHALL shift in; no wrap or increment is applied; all ADDR_W bits are passed through.

Reset
REQ-033 arst_n low SHALL immediately force state = IDLE and set cmd_valid, tx_valid, err, cmd_we, cmd_addr, cmd_wdata, tx_data and the timeout counter to 0.
REQ-034 Reset mid-command or mid-transmission SHALL abandon the operation, with no request and no byte emitted after reset release.
REQ-035 The first byte after reset release SHALL be treated as an opcode.

Structure
REQ-036 A shared package psram_pkg SHALL hold:
  - OPC_READ and OPC_WRITE constants;
  - the parser state enum typedef;
  - the ADDR_W default.
REQ-037 The timeout counter SHALL be a separate sub-module, byte_timeout, with ports clk, arst_n, tick_1us, clear, enable, expired.

Verification
REQ-038 Read sequence: bytes 00,22,33,44 -> cmd_valid with cmd_we=0, cmd_addr=0x223344; after rd_valid with rd_data=0xBEEF, tx emits 0xBE then 0xEF.
REQ-039 Write sequence: bytes 01,02,03,04,07,07 -> one request with cmd_we=1, cmd_addr=0x020304, cmd_wdata=0x0707; cmd_ready held low for 5 cycles -> outputs stable and a single accept.
REQ-040 Bad opcode: byte 0x05 -> one err pulse, no cmd_valid; a following 00,00,00,10 -> a read of address 0x000010.
REQ-041 Timeout: bytes 00,12 then silence for TIMEOUT_US+10 us -> err pulse and return to IDLE; the next 00,AA,BB,CC -> a read of address 0xAABBCC.
REQ-042 Overrun: a byte sent during WAIT_RD -> err pulse; tx still emits the correct two bytes.
REQ-043 Reset mid-operation: arst_n asserted during TX_HI with tx_ready=0 -> tx_valid=0 at once; no tx_valid after release until a new read completes.

Source files
------------

// File: rtl/psram_pkg.sv
// Shared definitions for the UART-to-PSRAM command path: opcodes,
// parser state encoding and the default PSRAM address width.
package psram_pkg;

  localparam int ADDR_W_DEFAULT = 24;

  localparam logic [7:0] OPC_READ  = 8'h00;
  localparam logic [7:0] OPC_WRITE = 8'h01;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    ISSUE,
    WAIT_RD,
    TX_HI,
    TX_LO
  } parser_state_e;

endpackage

// File: rtl/byte_timeout.sv
// Inter-byte timeout: counts 1 us ticks while enabled, restarts on every
// received byte and flags expiry once TIMEOUT_US ticks have elapsed.
// The counter self-clears on expiry so it reads 0 once the parser has
// fallen back to IDLE.
module byte_timeout #(
  parameter int TIMEOUT_US = 2000
) (
  input  logic clk,
  input  logic arst_n,
  input  logic tick_1us,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_US);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  assign expired = enable && (cnt_q >= LIMIT);

  // Next count: zero outside the collecting states, on a byte or on expiry.
  always_comb begin
    cnt_d = cnt_q;
    if (!enable || clear || expired) begin
      cnt_d = '0;
    end else if (tick_1us) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// UART command parser: turns opcode/address/data byte streams into PSRAM
// read/write requests and sends read results back as two bytes, MSB first.
// Any protocol violation (bad opcode, byte while busy, inter-byte timeout)
// produces a one-cycle err pulse.
module uart_cmd_parser
  import psram_pkg::*;
#(
  parameter int TIMEOUT_US = 2000,
  parameter int ADDR_W     = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              tick_1us,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_we,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [15:0]       cmd_wdata,
  input  logic [15:0]       rd_data,
  input  logic              rd_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              err
);

  parser_state_e     state_q, state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              cmd_we_q, cmd_we_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [15:0]       cmd_wdata_q, cmd_wdata_d;
  logic [7:0]        rd_lo_q, rd_lo_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              err_q, err_d;

  logic              to_enable;
  logic              to_expired;

  assign to_enable = (state_q == ADDR) || (state_q == DATA);

  byte_timeout #(
    .TIMEOUT_US(TIMEOUT_US)
  ) u_byte_timeout (
    .clk     (clk),
    .arst_n  (arst_n),
    .tick_1us(tick_1us),
    .clear   (rx_valid),
    .enable  (to_enable),
    .expired (to_expired)
  );

  assign cmd_valid = cmd_valid_q;
  assign cmd_we    = cmd_we_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_wdata = cmd_wdata_q;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign err       = err_q;

  // Parser next-state and output decode; a received byte beats a timeout.
  always_comb begin
    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    cmd_valid_d = cmd_valid_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    rd_lo_d     = rd_lo_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          if ((rx_data == OPC_READ) || (rx_data == OPC_WRITE)) begin
            cmd_we_d   = (rx_data == OPC_WRITE);
            cmd_addr_d = '0;
            byte_idx_d = 2'd0;
            state_d    = ADDR;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ADDR: begin
        if (rx_valid) begin
          cmd_addr_d = {cmd_addr_q[ADDR_W-9:0], rx_data};
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd2) begin
            byte_idx_d = 2'd0;
            if (cmd_we_q) begin
              state_d = DATA;
            end else begin
              state_d     = ISSUE;
              cmd_valid_d = 1'b1;
            end
          end
        end else if (to_expired) begin
          state_d    = IDLE;
          cmd_addr_d = '0;
          err_d      = 1'b1;
        end
      end

      DATA: begin
        if (rx_valid) begin
          cmd_wdata_d = {cmd_wdata_q[7:0], rx_data};
          byte_idx_d  = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd1) begin
            byte_idx_d  = 2'd0;
            state_d     = ISSUE;
            cmd_valid_d = 1'b1;
          end
        end else if (to_expired) begin
          state_d     = IDLE;
          cmd_addr_d  = '0;
          cmd_wdata_d = '0;
          err_d       = 1'b1;
        end
      end

      ISSUE: begin
        err_d = rx_valid;
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = cmd_we_q ? IDLE : WAIT_RD;
        end
      end

      WAIT_RD: begin
        err_d = rx_valid;
        if (rd_valid) begin
          rd_lo_d    = rd_data[7:0];
          tx_data_d  = rd_data[15:8];
          tx_valid_d = 1'b1;
          state_d    = TX_HI;
        end
      end

      TX_HI: begin
        err_d = rx_valid;
        if (tx_ready) begin
          tx_data_d = rd_lo_q;
          state_d   = TX_LO;
        end
      end

      TX_LO: begin
        err_d = rx_valid;
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          tx_data_d  = '0;
          state_d    = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        cmd_valid_d = 1'b0;
        tx_valid_d  = 1'b0;
      end
    endcase
  end

  // Parser state and registered outputs; reset abandons any command in flight.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= IDLE;
      byte_idx_q  <= '0;
      cmd_valid_q <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      rd_lo_q     <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      rd_lo_q     <= rd_lo_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      err_q       <= err_d;
    end
  end

endmodule
